// File: rtl/led_state_decoder.sv
// Classifies a monitored LED drive as steady ON, steady OFF, BLINK or UNKNOWN by timing its edges.
// Latency: an i_led change is acted on 3 clk later; o_chg follows o_state by 1 clk. No backpressure.
module led_state_decoder #(
    parameter int TICK_DIV     = 50000,
    parameter int BLINK_MIN    = 100,
    parameter int BLINK_MAX    = 500,
    parameter int STEADY_TICKS = 1000,
    parameter int CONFIRM      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_led,
    output logic [1:0]  o_state,
    output logic        o_chg,
    output logic [15:0] o_half_period,
    output logic        o_err
);

    typedef enum logic [1:0] {
        ST_ON      = 2'b00,
        ST_OFF     = 2'b01,
        ST_BLINK   = 2'b10,
        ST_UNKNOWN = 2'b11
    } state_t;

    state_t      state, state_nxt, state_d1;
    logic        led_s1, led_s2, led_s3;
    logic        led_edge;
    logic [15:0] presc;
    logic        tick;
    logic [15:0] tick_cnt, cnt_inc, cnt_nxt;
    logic        steady;
    logic        in_range;
    logic [3:0]  conf, conf_inc, conf_nxt;
    logic        valid, valid_nxt;
    logic [15:0] hp_nxt;
    logic        err_nxt;
    logic        chg_q;

    // Synchronizer keeps running regardless of i_en so re-enable sees a settled level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_s1 <= 1'b0;
            led_s2 <= 1'b0;
            led_s3 <= 1'b0;
        end else begin
            led_s1 <= i_led;
            led_s2 <= led_s1;
            led_s3 <= led_s2;
        end
    end

    assign led_edge = led_s2 ^ led_s3;

    assign tick = (presc == 16'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!i_en || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // Count including the current tick, so a measurement reports ticks elapsed up to the edge.
    assign cnt_inc  = (tick && tick_cnt != 16'hFFFF) ? tick_cnt + 16'd1 : tick_cnt;
    assign steady   = tick && !led_edge && (cnt_inc == 16'(STEADY_TICKS));
    assign in_range = (cnt_inc >= 16'(BLINK_MIN)) && (cnt_inc <= 16'(BLINK_MAX));
    assign conf_inc = (conf == 4'(CONFIRM)) ? conf : conf + 4'd1;

    always_comb begin
        state_nxt = state;
        valid_nxt = valid;
        conf_nxt  = conf;
        hp_nxt    = o_half_period;
        err_nxt   = 1'b0;
        cnt_nxt   = cnt_inc;
        if (!i_en) begin
            state_nxt = ST_UNKNOWN;
            valid_nxt = 1'b0;
            conf_nxt  = '0;
            cnt_nxt   = '0;
        end else if (led_edge) begin
            cnt_nxt = '0;
            if (state == ST_ON || state == ST_OFF) begin
                state_nxt = ST_UNKNOWN;
                valid_nxt = 1'b1;
            end else if (!valid) begin
                // First edge after a restart only marks the start of a half-period.
                valid_nxt = 1'b1;
            end else begin
                hp_nxt = cnt_inc;
                if (in_range) begin
                    conf_nxt = conf_inc;
                    if (conf_inc == 4'(CONFIRM) && state != ST_BLINK) begin
                        state_nxt = ST_BLINK;
                    end
                end else begin
                    conf_nxt = '0;
                    err_nxt  = 1'b1;
                    if (state == ST_BLINK) begin
                        state_nxt = ST_UNKNOWN;
                    end
                end
            end
        end else if (steady) begin
            state_nxt = led_s2 ? ST_OFF : ST_ON;
            conf_nxt  = '0;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_UNKNOWN;
            state_d1      <= ST_UNKNOWN;
            tick_cnt      <= '0;
            conf          <= '0;
            valid         <= 1'b0;
            o_half_period <= '0;
            o_err         <= 1'b0;
            chg_q         <= 1'b0;
        end else begin
            state         <= state_nxt;
            state_d1      <= state;
            tick_cnt      <= cnt_nxt;
            conf          <= conf_nxt;
            valid         <= valid_nxt;
            o_half_period <= hp_nxt;
            o_err         <= err_nxt;
            chg_q         <= i_en && (state != state_d1);
        end
    end

    assign o_state = state;
    assign o_chg   = chg_q;

endmodule
